btb_update_ctrl: RTL and testbench
==================================

// Module: btb_update_ctrl
// PURPOSE
//  Sequences all writes into the single-write-port branch target buffer. Buffers resolved-branch
//  updates from NUM_REQ branch units in a coalescing FIFO and drains one per cycle to the BTB write
//  port. Also runs a full-table invalidation walk on request. Sits between execute/branch units and btb.
// PARAMETERS
//  DEPTH        `BRANCH_TARGET_BUFFER_SIZE  BTB entries (power of 2); LOG_DEPTH = $clog2(DEPTH)
//  QUEUE_DEPTH  4                           update FIFO entries; must be >= NUM_REQ
//  NUM_REQ      2                           update request ports
// PORTS
//  clock          in   1                  system clock
//  reset_n        in   1                  asynchronous reset, active low
//  req_valid      in   NUM_REQ            update request per port
//  req_pc         in   ADDR[NUM_REQ]      resolved taken-branch PC
//  req_target     in   ADDR[NUM_REQ]      resolved target
//  req_ready      out  1                  all ports may present this cycle
//  inval_req      in   1                  start full-BTB invalidation
//  inval_busy     out  1                  invalidation walk in progress
//  inval_done     out  1                  one-cycle pulse, last invalidate write issued
//  btb_wr_en      out  1                  BTB write enable (registered)
//  btb_wr_pc      out  ADDR               BTB write PC (registered)
//  btb_wr_target  out  ADDR               BTB write target (registered)
//  q_count        out  $clog2(QUEUE_DEPTH+1)  valid FIFO entries
// BEHAVIOUR
//  - Reset (async, reset_n=0): FIFO empty, head/tail/count 0, state IDLE, all outputs 0.
//  - States: IDLE (drain FIFO) and INVAL. IDLE->INVAL on inval_req; INVAL->IDLE after index DEPTH-1.
//  - req_ready = (state==IDLE) & ~inval_req & (QUEUE_DEPTH - q_count >= NUM_REQ); no dependence
//    on req_valid. Port i accepted at edge iff req_valid[i] & req_ready.
//  - Accept order: port 0 before port 1 (lower index enqueued first).
//  - Coalescing: accepted PC equal to a valid non-head-being-popped FIFO entry overwrites that entry's
//    target in place, no new slot. Same PC on two ports same cycle: one slot, higher port's target.
//    Entry being popped this cycle is never coalesced into; match yields new slot.
//  - Drain: in IDLE with q_count>0, head popped each edge; next cycle btb_wr_en=1, btb_wr_pc/target
//    = popped entry. Accept-to-write latency 1 cycle on empty FIFO. btb_wr_en=0 when nothing popped.
//  - Simultaneous push+pop allowed; q_count += accepted_new - popped; head/tail wrap mod QUEUE_DEPTH.
//  - inval_req in IDLE: FIFO contents discarded (count->0) at same edge, no pop that edge; state INVAL.
//    inval_req while INVAL ignored.
//  - INVAL: index counter 0..DEPTH-1, one per cycle; output cycle k: btb_wr_en=1,
//    btb_wr_pc = k << 3 (bits [LOG_DEPTH+2:3] = k, others 0), btb_wr_target = 0 (zero target reads
//    as not-a-branch). inval_busy=1 in all INVAL cycles. inval_done=1 in cycle btb write k=DEPTH-1
//    is presented; next cycle state IDLE, req_ready may reassert.
//  - Reset mid-walk or mid-drain: immediate return to reset state; partial walk not resumed.
//  - Arithmetic: index counter LOG_DEPTH+1 bits; count saturates never (guarded by req_ready).
// TESTING
//  1. Idle, req0 pc=0x40 tgt=0x100 -> next cycle btb_wr_en=1, pc=0x40, tgt=0x100; following cycle en=0.
//  2. Same cycle req0 0x40->0x100, req1 0x80->0x200 -> writes 0x40 then 0x80 on consecutive cycles.
//  3. Same cycle req0,req1 both pc 0x40, tgts 0x100/0x300 -> exactly one write, tgt 0x300, q_count<=1.
//  4. QUEUE_DEPTH=4, both ports valid distinct PCs every cycle -> req_ready drops when q_count>2;
//     no update lost, write order equals accept order.
//  5. Queue holding 3 entries, pulse inval_req, DEPTH=32 -> queued entries never written; 32 writes
//     pc=0x0,0x8..0xF8 tgt=0; inval_done with pc=0xF8; inval_busy 32 cycles; req_ready=0 throughout.
//  6. reset_n low at walk index 10 -> outputs 0 immediately; after release req pc=0x40 handled as test 1.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// Write sequencer for the single-port BTB: coalescing update FIFO drained one entry per cycle,
// plus a full-table invalidation walk that presents zero targets for every index.
module btb_update_ctrl #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  localparam int unsigned LOG_DEPTH  = $clog2(DEPTH),
  localparam int unsigned PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1,
  localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_pc,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_target,
  output logic                          req_ready,
  input  logic                          inval_req,
  output logic                          inval_busy,
  output logic                          inval_done,
  output logic                          btb_wr_en,
  output logic [ADDR_WIDTH-1:0]         btb_wr_pc,
  output logic [ADDR_WIDTH-1:0]         btb_wr_target,
  output logic [CNT_W-1:0]              q_count
);

  typedef enum logic {StIdle, StInval} state_e;

  state_e                  state_q, state_d;
  logic [LOG_DEPTH:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   pc_q  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_d  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   tgt_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   tgt_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_pc_q, wr_pc_d, wr_tgt_q, wr_tgt_d;
  logic                    pop, hit;
  logic [PTR_W-1:0]        slot;
  int unsigned             n_new;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= QUEUE_DEPTH) s = s - QUEUE_DEPTH;
    return PTR_W'(s);
  endfunction

  assign req_ready = (state_q == StIdle) & ~inval_req &
                     ((QUEUE_DEPTH - 32'(count_q)) >= NUM_REQ);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    vld_d    = vld_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_en_d  = 1'b0;
    wr_pc_d  = '0;
    wr_tgt_d = '0;
    pop      = 1'b0;
    hit      = 1'b0;
    slot     = '0;
    n_new    = 0;
    case (state_q)
      StIdle: begin
        if (inval_req) begin
          // Queue is discarded; the first walk write (index 0, all-zero) is loaded now.
          state_d = StInval;
          idx_d   = '0;
          vld_d   = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
          wr_en_d = 1'b1;
        end else begin
          if (count_q != '0) begin
            pop           = 1'b1;
            wr_en_d       = 1'b1;
            wr_pc_d       = pc_q[head_q];
            wr_tgt_d      = tgt_q[head_q];
            vld_d[head_q] = 1'b0;
            head_d        = ptr_add(head_q, 1);
          end
          // Head is already invalidated above, so it can never absorb a coalesce.
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_valid[i] && req_ready) begin
              hit = 1'b0;
              for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
                if (vld_d[j] && (pc_d[j] == req_pc[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                  tgt_d[j] = req_target[i*ADDR_WIDTH +: ADDR_WIDTH];
                  hit      = 1'b1;
                end
              end
              if (!hit) begin
                slot        = ptr_add(tail_q, n_new);
                vld_d[slot] = 1'b1;
                pc_d[slot]  = req_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
                tgt_d[slot] = req_target[i*ADDR_WIDTH +: ADDR_WIDTH];
                n_new       = n_new + 1;
              end
            end
          end
          tail_d  = ptr_add(tail_q, n_new);
          count_d = count_q + CNT_W'(n_new) - CNT_W'(pop);
        end
      end
      StInval: begin
        if (idx_q == (LOG_DEPTH+1)'(DEPTH - 1)) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d                    = idx_q + 1'b1;
          wr_en_d                  = 1'b1;
          wr_pc_d[LOG_DEPTH+2:3]   = idx_d[LOG_DEPTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      wr_en_q  <= 1'b0;
      wr_pc_q  <= '0;
      wr_tgt_q <= '0;
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
        pc_q[j]  <= '0;
        tgt_q[j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_en_q  <= wr_en_d;
      wr_pc_q  <= wr_pc_d;
      wr_tgt_q <= wr_tgt_d;
      for (int j = 0; j < int'(QUEUE_DEPTH); j++) begin
        pc_q[j]  <= pc_d[j];
        tgt_q[j] <= tgt_d[j];
      end
    end
  end

  assign inval_busy    = (state_q == StInval);
  assign inval_done    = (state_q == StInval) && (idx_q == (LOG_DEPTH+1)'(DEPTH - 1));
  assign btb_wr_en     = wr_en_q;
  assign btb_wr_pc     = wr_pc_q;
  assign btb_wr_target = wr_tgt_q;
  assign q_count       = count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed vector table, hand-written walk/reset/backpressure sequences
// and random traffic checked against a queue-based reference model.
module tb_btb_update_ctrl;
  localparam int DEPTH = 32;
  localparam int QD    = 4;
  localparam int NR    = 2;
  localparam int AW    = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_pc, req_target;
  logic          req_ready, inval_req, inval_busy, inval_done, btb_wr_en;
  logic [AW-1:0] btb_wr_pc, btb_wr_target;
  logic [2:0]    q_count;

  btb_update_ctrl #(.DEPTH(DEPTH), .QUEUE_DEPTH(QD), .NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_pc(req_pc),
    .req_target(req_target), .req_ready(req_ready), .inval_req(inval_req),
    .inval_busy(inval_busy), .inval_done(inval_done), .btb_wr_en(btb_wr_en),
    .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .q_count(q_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending updates as an ordered list, walk as a list of remaining writes.
  typedef struct packed {logic [31:0] pc; logic [31:0] tgt;} ent_t;
  ent_t mq[$];
  ent_t walk[$];
  bit          m_busy, m_en;
  logic [31:0] m_pc, m_tgt;
  bit          last_ready;

  function automatic bit model_ready(input logic inv);
    return !m_busy && !inv && ((QD - mq.size()) >= NR);
  endfunction

  task automatic model_reset();
    mq.delete(); walk.delete();
    m_busy = 0; m_en = 0; m_pc = 0; m_tgt = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [31:0] p0, t0, p1, t1,
                            input logic inv, input bit rdy);
    ent_t e;
    bit hit;
    logic [31:0] pcs[2];
    logic [31:0] tgs[2];
    pcs[0] = p0; pcs[1] = p1; tgs[0] = t0; tgs[1] = t1;
    m_en = 0; m_pc = 0; m_tgt = 0;
    if (m_busy) begin
      if (walk.size() > 0) begin
        e = walk.pop_front(); m_en = 1; m_pc = e.pc; m_tgt = e.tgt;
      end else m_busy = 0;
    end else if (inv) begin
      mq.delete();
      for (int k = 0; k < DEPTH; k++) walk.push_back('{pc: 32'(k * 8), tgt: 32'd0});
      e = walk.pop_front(); m_en = 1; m_pc = e.pc; m_tgt = e.tgt; m_busy = 1;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front(); m_en = 1; m_pc = e.pc; m_tgt = e.tgt;
      end
      if (rdy) begin
        for (int p = 0; p < NR; p++) begin
          if (v[p]) begin
            hit = 0;
            foreach (mq[j]) if (mq[j].pc == pcs[p]) begin mq[j].tgt = tgs[p]; hit = 1; end
            if (!hit) mq.push_back('{pc: pcs[p], tgt: tgs[p]});
          end
        end
      end
    end
  endtask

  // Entered and left at a negedge; inputs driven here, outputs checked at the next negedge.
  task automatic cycle(input logic [1:0] v, input logic [31:0] p0, t0, p1, t1, input logic inv);
    bit r;
    req_valid = v; req_pc = {p1, p0}; req_target = {t1, t0}; inval_req = inv;
    #1;
    r = model_ready(inv);
    chk("req_ready", 32'(req_ready), 32'(r));
    last_ready = req_ready;
    @(posedge clock);
    model_step(v, p0, t0, p1, t1, inv, r);
    @(negedge clock);
    chk("wr_en", 32'(btb_wr_en), 32'(m_en));
    if (m_en) begin
      chk("wr_pc", btb_wr_pc, m_pc);
      chk("wr_target", btb_wr_target, m_tgt);
    end
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("inval_busy", 32'(inval_busy), 32'(m_busy));
    chk("inval_done", 32'(inval_done), 32'(m_busy && walk.size() == 0));
  endtask

  task automatic idle();
    cycle(2'b00, 0, 0, 0, 0, 1'b0);
  endtask

  typedef struct {
    logic [1:0] v; logic [31:0] p0, t0, p1, t1;
    logic en; logic [31:0] epc, etgt; int q;
  } vec_t;
  vec_t vecs[15];

  function automatic vec_t mk(input logic [1:0] v, input logic [31:0] p0, t0, p1, t1,
                              input logic en, input logic [31:0] epc, etgt, input int q);
    vec_t r;
    r.v = v; r.p0 = p0; r.t0 = t0; r.p1 = p1; r.t1 = t1;
    r.en = en; r.epc = epc; r.etgt = etgt; r.q = q;
    return r;
  endfunction

  logic [31:0] acc_list[$];
  logic [31:0] wr_list[$];
  bit          saw_drop;
  logic [31:0] pool[5];

  initial begin
    vecs[0]  = mk(2'b01, 'h40, 'h100, 0, 0,         0, 0, 0, 1);
    vecs[1]  = mk(2'b00, 0, 0, 0, 0,                1, 'h40, 'h100, 0);
    vecs[2]  = mk(2'b00, 0, 0, 0, 0,                0, 0, 0, 0);
    vecs[3]  = mk(2'b11, 'h40, 'h100, 'h80, 'h200, 0, 0, 0, 2);
    vecs[4]  = mk(2'b00, 0, 0, 0, 0,                1, 'h40, 'h100, 1);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0,                1, 'h80, 'h200, 0);
    vecs[6]  = mk(2'b11, 'h40, 'h100, 'h40, 'h300, 0, 0, 0, 1);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0,                1, 'h40, 'h300, 0);
    vecs[8]  = mk(2'b00, 0, 0, 0, 0,                0, 0, 0, 0);
    vecs[9]  = mk(2'b11, 'hA0, 'h1, 'hB0, 'h2,      0, 0, 0, 2);
    vecs[10] = mk(2'b01, 'hB0, 'h5, 0, 0,           1, 'hA0, 'h1, 1);
    vecs[11] = mk(2'b00, 0, 0, 0, 0,                1, 'hB0, 'h5, 0);
    vecs[12] = mk(2'b01, 'hC0, 'h7, 0, 0,           0, 0, 0, 1);
    vecs[13] = mk(2'b01, 'hC0, 'h8, 0, 0,           1, 'hC0, 'h7, 1);
    vecs[14] = mk(2'b00, 0, 0, 0, 0,                1, 'hC0, 'h8, 0);
    pool[0] = 'h40; pool[1] = 'h80; pool[2] = 'hC0; pool[3] = 'h100; pool[4] = 'h140;

    req_valid = '0; req_pc = '0; req_target = '0; inval_req = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("rst_wr_en", 32'(btb_wr_en), 0);
    chk("rst_wr_pc", btb_wr_pc, 0);
    chk("rst_wr_target", btb_wr_target, 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_busy", 32'(inval_busy), 0);
    chk("rst_done", 32'(inval_done), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed vectors: single write, two-port ordering, same-cycle and queued coalescing.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].v, vecs[i].p0, vecs[i].t0, vecs[i].p1, vecs[i].t1, 1'b0);
      chk($sformatf("vec%0d_en", i), 32'(btb_wr_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        chk($sformatf("vec%0d_pc", i), btb_wr_pc, vecs[i].epc);
        chk($sformatf("vec%0d_tgt", i), btb_wr_target, vecs[i].etgt);
      end
      chk($sformatf("vec%0d_q", i), 32'(q_count), 32'(vecs[i].q));
    end

    // Invalidation with three queued entries that must never be written.
    cycle(2'b11, 'h200, 'h1, 'h208, 'h2, 1'b0);
    cycle(2'b11, 'h210, 'h3, 'h218, 'h4, 1'b0);
    chk("pre_inval_q", 32'(q_count), 3);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(2'b11, 'h300, 'h9, 'h308, 'hA, (k == 0 || k == 5));
      chk("walk_ready", 32'(last_ready), 0);
      chk("walk_en", 32'(btb_wr_en), 1);
      chk("walk_pc", btb_wr_pc, 32'(k * 8));
      chk("walk_tgt", btb_wr_target, 0);
      chk("walk_busy", 32'(inval_busy), 1);
      chk("walk_done", 32'(inval_done), 32'(k == DEPTH - 1));
      chk("walk_q", 32'(q_count), 0);
    end
    idle();
    chk("post_walk_en", 32'(btb_wr_en), 0);
    chk("post_walk_busy", 32'(inval_busy), 0);
    idle();
    chk("post_walk_en2", 32'(btb_wr_en), 0);

    // Backpressure: both ports every cycle with distinct PCs; order and completeness.
    saw_drop = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(2'b11, 32'h1000 + 32'(c * 16), 32'(c), 32'h1008 + 32'(c * 16), 32'(c + 100), 1'b0);
      if (last_ready) begin
        acc_list.push_back(32'h1000 + 32'(c * 16));
        acc_list.push_back(32'h1008 + 32'(c * 16));
      end else saw_drop = 1;
      if (btb_wr_en) wr_list.push_back(btb_wr_pc);
      chk("bp_q_bound", 32'(q_count <= 3'(QD)), 1);
    end
    for (int c = 0; c < 6; c++) begin
      idle();
      if (btb_wr_en) wr_list.push_back(btb_wr_pc);
    end
    chk("bp_ready_dropped", 32'(saw_drop), 1);
    chk("bp_write_count", 32'(wr_list.size()), 32'(acc_list.size()));
    for (int i = 0; i < acc_list.size() && i < wr_list.size(); i++)
      chk($sformatf("bp_order%0d", i), wr_list[i], acc_list[i]);

    // Reset mid-walk at index 10, then a fresh single update.
    cycle(2'b00, 0, 0, 0, 0, 1'b1);
    for (int k = 1; k <= 10; k++) idle();
    chk("mid_walk_pc", btb_wr_pc, 32'h50);
    reset_n = 1'b0;
    #1;
    chk("mrst_en", 32'(btb_wr_en), 0);
    chk("mrst_pc", btb_wr_pc, 0);
    chk("mrst_busy", 32'(inval_busy), 0);
    chk("mrst_done", 32'(inval_done), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle(2'b01, 'h40, 'h100, 0, 0, 1'b0);
    idle();
    chk("mrst_t1_en", 32'(btb_wr_en), 1);
    chk("mrst_t1_pc", btb_wr_pc, 'h40);
    chk("mrst_t1_tgt", btb_wr_target, 'h100);
    idle();
    chk("mrst_t1_en_off", 32'(btb_wr_en), 0);

    // Random traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      cycle(2'($urandom_range(0, 3)), pool[$urandom_range(0, 4)], $urandom,
            pool[$urandom_range(0, 4)], $urandom, ($urandom_range(0, 59) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
